// File: rtl/digitos_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package digitos_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble corrector: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import digitos_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] corrected
);

    assign corrected = (digit >= ADD3_THRESH) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/digitos_bcd_secuencial.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define DIGITOS_SIGNED_EN to treat numero as two's complement (sign on neg).
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high once out of reset
// SHIFT | one add-3/shift step per cycle until the bit counter reaches zero
// DONE  | result presented with out_valid until out_ready
module digitos_bcd_secuencial
    import digitos_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int N_DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_W-1:0]         numero,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [4*N_DIGITS-1:0]     digits,
    output logic                      overflow,
    output logic                      neg,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int BCD_TOT = BCD_W * N_DIGITS;
    localparam int CNT_W   = $clog2(DATA_W + 1);

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    mag;
    logic [DATA_W-1:0]    bin_q;
    logic [BCD_TOT-1:0]   bcd_q;
    logic [BCD_TOT-1:0]   bcd_adj;
    logic [BCD_TOT-1:0]   digits_q;
    logic                 ovf_q;
    logic                 overflow_q;
    logic                 armed_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept;
    logic                 finish;

    // armed_q keeps in_ready low until the first edge after reset release
    assign in_ready  = (state == IDLE) && armed_q;
    assign accept    = in_valid && in_ready;
    assign finish    = (state == SHIFT) && (cnt_q == '0);
    assign out_valid = (state == DONE);
    assign digits    = digits_q;
    assign overflow  = overflow_q;

`ifdef DIGITOS_SIGNED_EN
    logic sign_q;
    logic neg_q;

    // the most negative value negates to itself, which is its correct unsigned magnitude
    assign mag = numero[DATA_W-1] ? (~numero + DATA_W'(1)) : numero;
    assign neg = neg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            if (accept)
                sign_q <= numero[DATA_W-1];
            if (finish)
                neg_q <= sign_q;
        end
    end
`else
    assign mag = numero;
    assign neg = 1'b0;
`endif

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (bcd_q  [BCD_W*k +: BCD_W]),
            .corrected (bcd_adj[BCD_W*k +: BCD_W])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SHIFT;
            SHIFT:   if (finish)    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q    <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                bin_q <= mag;
                bcd_q <= '0;
                ovf_q <= 1'b0;
                cnt_q <= CNT_W'(DATA_W);
            end else if (state == SHIFT) begin
                if (cnt_q != '0) begin
                    // carry out of the top digit is dropped, leaving magnitude mod 10^N
                    bcd_q <= {bcd_adj[BCD_TOT-2:0], bin_q[DATA_W-1]};
                    bin_q <= {bin_q[DATA_W-2:0], 1'b0};
                    ovf_q <= ovf_q | bcd_adj[BCD_TOT-1];
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    digits_q   <= bcd_q;
                    overflow_q <= ovf_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_digitos_bcd_secuencial.sv
// Self-checking bench for digitos_bcd_secuencial (default 32-bit, 6-digit build).
module tb_digitos_bcd_secuencial;

    localparam int DATA_W   = 32;
    localparam int N_DIGITS = 6;
    localparam int LAT      = DATA_W + 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [DATA_W-1:0]      numero;
    logic                   in_valid;
    logic                   in_ready;
    logic [4*N_DIGITS-1:0]  digits;
    logic                   overflow;
    logic                   neg;
    logic                   out_valid;
    logic                   out_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] num;
        logic [23:0] dig;
        logic        ovf;
        logic        ng;
    } vec_t;

    vec_t vecs[8];

    digitos_bcd_secuencial #(.DATA_W(DATA_W), .N_DIGITS(N_DIGITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .numero    (numero),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .digits    (digits),
        .overflow  (overflow),
        .neg       (neg),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal value of the magnitude, reduced mod 10^6, written out as BCD.
    task automatic model(input logic [31:0] n, output logic [23:0] dig,
                         output logic ovf, output logic ng);
        longint mag;
        longint r;
`ifdef DIGITOS_SIGNED_EN
        ng  = n[31];
        mag = n[31] ? (longint'(1) << 32) - longint'(n) : longint'(n);
`else
        ng  = 1'b0;
        mag = longint'(n);
`endif
        ovf = (mag > 999999);
        r   = mag % 1000000;
        dig = '0;
        for (int k = 0; k < 6; k++) begin
            dig[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_conv(input logic [31:0] n, input logic [23:0] e_dig,
                            input logic e_ovf, input logic e_neg, input string tag);
        int lat;
        @(negedge clk);
        wait_ready(tag);
        numero   = n;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check({tag, "_latency"},  64'(lat), 64'(LAT));
        check({tag, "_digits"},   64'(digits), 64'(e_dig));
        check({tag, "_overflow"}, 64'(overflow), 64'(e_ovf));
        check({tag, "_neg"},      64'(neg), 64'(e_neg));
        consume();
        check({tag, "_release"},  64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [23:0] e_dig;
        logic        e_ovf, e_neg;
        logic [31:0] rn;
        int          lat;
        int          seen;

`ifdef DIGITOS_SIGNED_EN
        vecs[0] = '{32'd123456,     24'h123456, 1'b0, 1'b0};
        vecs[1] = '{32'd1234567,    24'h234567, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF,   24'h000001, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000,   24'h483648, 1'b1, 1'b1};
        vecs[4] = '{32'd0,          24'h000000, 1'b0, 1'b0};
        vecs[5] = '{32'd999999,     24'h999999, 1'b0, 1'b0};
        vecs[6] = '{32'd1000000,    24'h000000, 1'b1, 1'b0};
        vecs[7] = '{-32'sd999999,   24'h999999, 1'b0, 1'b1};
`else
        vecs[0] = '{32'd123456,     24'h123456, 1'b0, 1'b0};
        vecs[1] = '{32'd1234567,    24'h234567, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF,   24'h967295, 1'b1, 1'b0};
        vecs[3] = '{32'h80000000,   24'h483648, 1'b1, 1'b0};
        vecs[4] = '{32'd0,          24'h000000, 1'b0, 1'b0};
        vecs[5] = '{32'd999999,     24'h999999, 1'b0, 1'b0};
        vecs[6] = '{32'd1000000,    24'h000000, 1'b1, 1'b0};
        vecs[7] = '{32'd10,         24'h000010, 1'b0, 1'b0};
`endif

        reset_n   = 1'b0;
        numero    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  64'(in_ready),  0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_digits",    64'(digits),    0);
        check("rst_overflow",  64'(overflow),  0);
        check("rst_neg",       64'(neg),       0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", 64'(in_ready), 0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_edge", 64'(in_ready), 1);

        for (int i = 0; i < 8; i++)
            run_conv(vecs[i].num, vecs[i].dig, vecs[i].ovf, vecs[i].ng, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rn = (i % 2 == 0) ? 32'($urandom_range(0, 999999)) : $urandom;
            model(rn, e_dig, e_ovf, e_neg);
            run_conv(rn, e_dig, e_ovf, e_neg, $sformatf("rnd%0d", i));
        end

        // Back-pressure: result held, new requests ignored until out_ready.
        model(32'd654321, e_dig, e_ovf, e_neg);
        @(negedge clk);
        wait_ready("hold");
        numero   = 32'd654321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_busy_in_ready", 64'(in_ready), 0);
        wait_result(lat);
        check("hold_latency", 64'(lat), 64'(LAT));
        @(negedge clk);
        numero   = 32'd111;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_digits_c%0d", c), 64'(digits), 64'(e_dig));
            check($sformatf("hold_valid_c%0d", c), 64'(out_valid), 1);
            check($sformatf("hold_in_ready_c%0d", c), 64'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_idle_valid",    64'(out_valid), 0);
        check("hold_idle_in_ready", 64'(in_ready),  1);
        check("hold_idle_digits",   64'(digits),    64'(e_dig));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_shift_valid",  64'(out_valid), 0);
        check("hold_shift_digits", 64'(digits),    64'(e_dig));
        wait_result(lat);
        check("hold_next_latency", 64'(lat),      64'(LAT));
        check("hold_next_digits",  64'(digits),   64'h000111);
        check("hold_next_ovf",     64'(overflow), 0);
        consume();

        // Reset at the tenth shift cycle aborts the conversion.
        @(negedge clk);
        wait_ready("abort");
        numero   = 32'd888888;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 0);
        check("abort_in_ready",  64'(in_ready),  0);
        check("abort_digits",    64'(digits),    0);
        check("abort_overflow",  64'(overflow),  0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rel_in_ready", 64'(in_ready), 1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 0);
        run_conv(32'd999999, 24'h999999, 1'b0, 1'b0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/digitos_bcd_secuencial.md
DIGITOS_BCD_SECUENCIAL -- requirements
Module: digitos_bcd_secuencial

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning input binary width (range 4..64).
REQ-002 SHALL have parameter N_DIGITS, default 6, meaning number of BCD output digits (range 1..20).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port numero, input, DATA_W, meaning the value to convert; sampled on accept.
REQ-006 SHALL have port in_valid, input, 1, meaning numero is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept a value.
REQ-008 SHALL have port digits, output, 4*N_DIGITS, meaning packed BCD; digit k at bits [4k+3:4k], k=0 least significant.
REQ-009 SHALL have port overflow, output, 1, meaning the magnitude exceeds 10^N_DIGITS-1.
REQ-010 SHALL have port neg, output, 1, meaning the sign of the converted value.
REQ-011 SHALL have port out_valid, output, 1, meaning digits, overflow and neg hold a result.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes the result.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept occurs on an edge with in_valid=1 and in_ready=1.
REQ-015 SHALL on accept load the magnitude into the shift register, clear the BCD register and the overflow flag, load the bit counter with DATA_W, and go to SHIFT.
REQ-016 SHALL in SHIFT, each cycle, add 3 to every BCD digit >=5, then shift the {BCD,binary} register left by one bit and decrement the counter (double-dabble).
REQ-017 SHALL OR every bit shifted out of the top digit into a sticky overflow flag, so digits equal the magnitude mod 10^N_DIGITS.
REQ-018 SHALL leave SHIFT for DONE after exactly DATA_W shift cycles; out_valid rises DATA_W+1 edges after the accept edge.
REQ-019 SHALL hold digits, overflow, neg and out_valid=1 stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-020 SHALL ignore in_valid in SHIFT and DONE; there is no queuing.
REQ-021 SHALL keep digits, overflow and neg at their last values in IDLE and SHIFT with out_valid=0.
REQ-022 SHALL produce numero=0 -> all digits 0, overflow 0.

Reset
REQ-023 SHALL on reset_n=0 asynchronously force IDLE, and set digits=0, overflow=0, neg=0, out_valid=0 and in_ready=0 while reset is asserted.
REQ-024 SHALL on reset mid-SHIFT or in DONE abort the conversion and emit no result; in_ready=1 on the first edge after release.

Configuration
REQ-025 SHALL, with DIGITOS_SIGNED_EN defined, treat numero as two's complement: neg=MSB, convert |numero|; -2^(DATA_W-1) converts correctly as unsigned magnitude.
REQ-026 SHALL, without DIGITOS_SIGNED_EN, treat numero as unsigned and tie neg to 0.

Structure
REQ-027 SHALL place the state enum, BCD_W=4 and the add-3 threshold constant in shared package digitos_pkg.
REQ-028 SHALL use one sub-module, bcd_add3, instantiated N_DIGITS times as the per-digit corrector.

Verification
REQ-029 SHALL cover unsigned numero=123456 -> digits 6,5,4,3,2,1 (k=0..5), overflow 0, out_valid at accept+33 edges.
REQ-030 SHALL cover numero=1234567 -> digits 234567, overflow 1; numero=32'hFFFFFFFF -> 967295, overflow 1.
REQ-031 SHALL cover out_ready held 0 for 10 cycles after out_valid -> outputs stable; a new in_valid is ignored; accept occurs only after out_ready.
REQ-032 SHALL cover DIGITOS_SIGNED_EN with numero=32'hFFFFFFFF -> neg 1, digits 000001; with 32'h80000000 -> neg 1, 483648, overflow 1.
REQ-033 SHALL cover reset_n pulsed low at SHIFT cycle 10 -> out_valid stays 0, then a fresh conversion of 999999 yields 999999, overflow 0.
